// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the AXI master bridge.
//   state_e    : bridge FSM states
//   BURST_INCR : AXI INCR burst encoding
//   RESP_OKAY  : AXI OKAY response encoding
//   SIZE_8B    : AXI size code for a full 64-bit beat
package axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AWW  = 3'd3,
    ST_B    = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_8B    = 3'd3;

endpackage

// File: rtl/axi_master_bridge.sv
// AXI master front end arbitrating the IFU (read-only) and LSU (read/write)
// client ports onto a single 64-bit AXI bus, one transaction at a time.
//
// Optional feature macro: IFU_BURST_EN
//   defined   : IFU reads are LINE_BEATS-beat INCR bursts from a line-aligned
//               address; ifu_rlast marks only the final beat.
//   undefined : IFU reads are single beats at the unmodified address.
//
// Ports:
//   aclk, areset                 clock, async active-high reset
//   ifu_req/addr -> ifu_ready    IFU read request / same-cycle accept pulse
//   ifu_rvalid/rdata/rlast       IFU returned beat
//   lsu_req/we/addr/size/wdata/wstrb -> lsu_ready   LSU request / accept
//   lsu_rvalid/rdata, lsu_bvalid LSU read data / write completion
//   resp_err                     pulse on a non-OKAY rresp/bresp beat
//   AR/R/AW/W/B                  AXI master channels
module axi_master_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 4,
  parameter logic [3:0]  IFU_ID     = 4'd0,
  parameter logic [3:0]  LSU_ID     = 4'd1
) (
  input  logic              aclk,
  input  logic              areset,
  // IFU client
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_ready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rlast,
  // LSU client
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [2:0]        lsu_size,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [STRB_W-1:0] lsu_wstrb,
  output logic              lsu_ready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_bvalid,
  output logic              resp_err,
  // AR channel
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // R channel
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AW channel
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  // W channel
  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // B channel
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [LEN_W-1:0] BURST_LEN = LEN_W'(LINE_BEATS - 1);

  // IFU request shaping: line-aligned burst or plain single beat
`ifdef IFU_BURST_EN
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BEATS * 8 - 1);
  localparam logic [LEN_W-1:0]  IFU_ARLEN = BURST_LEN;
  logic [ADDR_W-1:0] ifu_araddr_c;
  assign ifu_araddr_c = ifu_addr & LINE_MASK;
`else
  localparam logic [LEN_W-1:0]  IFU_ARLEN = '0;
  logic [ADDR_W-1:0] ifu_araddr_c;
  assign ifu_araddr_c = ifu_addr;
`endif

  // rid/bid/rlast are not needed: one outstanding transaction, beat count is local
  logic unused_in;
  assign unused_in = ^{rid, bid, rlast, BURST_LEN};

  state_e state_q, state_d;
  logic              owner_lsu_q, owner_lsu_d;
  logic [LEN_W-1:0]  beat_q, beat_d;

  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;

  logic [ID_W-1:0]   awid_q, awid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [LEN_W-1:0]  awlen_q, awlen_d;
  logic [2:0]        awsize_q, awsize_d;
  logic [1:0]        awburst_q, awburst_d;
  logic              awvalid_q, awvalid_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              wlast_q, wlast_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;

  logic              ifu_rvalid_q, ifu_rvalid_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic              ifu_rlast_q, ifu_rlast_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              lsu_bvalid_q, lsu_bvalid_d;
  logic              resp_err_q, resp_err_d;

  // Fixed-priority grant; accept pulses in the same cycle the request is seen
  logic grant_lsu_c, grant_ifu_c;
  assign grant_lsu_c = (state_q == ST_IDLE) && lsu_req;
  assign grant_ifu_c = (state_q == ST_IDLE) && ifu_req && !lsu_req;
  assign lsu_ready   = grant_lsu_c && !areset;
  assign ifu_ready   = grant_ifu_c && !areset;

  // Handshake bookkeeping for the write address/data pair
  logic aw_pend_c, w_pend_c;
  assign aw_pend_c = awvalid_q && !awready;
  assign w_pend_c  = wvalid_q && !wready;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    owner_lsu_d  = owner_lsu_q;
    beat_d       = beat_q;
    araddr_d     = araddr_q;
    arid_d       = arid_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awid_d       = awid_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    awsize_d     = awsize_q;
    awburst_d    = awburst_q;
    awvalid_d    = awvalid_q;
    wid_d        = wid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wlast_d      = wlast_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    ifu_rvalid_d = 1'b0;
    ifu_rlast_d  = 1'b0;
    lsu_rvalid_d = 1'b0;
    lsu_bvalid_d = 1'b0;
    resp_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (grant_lsu_c) begin
          owner_lsu_d = 1'b1;
          if (lsu_we) begin
            state_d   = ST_AWW;
            awid_d    = LSU_ID;
            awaddr_d  = lsu_addr;
            awlen_d   = '0;
            awsize_d  = lsu_size;
            awburst_d = BURST_INCR;
            awvalid_d = 1'b1;
            wid_d     = LSU_ID;
            wdata_d   = lsu_wdata;
            wstrb_d   = lsu_wstrb;
            wlast_d   = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_AR;
            araddr_d  = lsu_addr;
            arid_d    = LSU_ID;
            arlen_d   = '0;
            arsize_d  = lsu_size;
            arburst_d = BURST_INCR;
            arvalid_d = 1'b1;
          end
        end else if (grant_ifu_c) begin
          owner_lsu_d = 1'b0;
          state_d     = ST_AR;
          araddr_d    = ifu_araddr_c;
          arid_d      = IFU_ID;
          arlen_d     = IFU_ARLEN;
          arsize_d    = SIZE_8B;
          arburst_d   = BURST_INCR;
          arvalid_d   = 1'b1;
        end
      end

      ST_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end

      // rready is held for the whole R state, so rvalid alone marks a beat
      ST_R: begin
        if (rvalid) begin
          resp_err_d = (rresp != RESP_OKAY);
          if (owner_lsu_q) begin
            lsu_rvalid_d = 1'b1;
            lsu_rdata_d  = rdata;
          end else begin
            ifu_rvalid_d = 1'b1;
            ifu_rdata_d  = rdata;
            ifu_rlast_d  = (beat_q == arlen_q);
          end
          if (beat_q == arlen_q) begin
            rready_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end

      // AW and W retire independently; leave once neither is pending
      ST_AWW: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!aw_pend_c && !w_pend_c) begin
          bready_d = 1'b1;
          state_d  = ST_B;
        end
      end

      ST_B: begin
        if (bvalid) begin
          bready_d     = 1'b0;
          lsu_bvalid_d = 1'b1;
          resp_err_d   = (bresp != RESP_OKAY);
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      owner_lsu_q  <= 1'b0;
      beat_q       <= '0;
      araddr_q     <= '0;
      arid_q       <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awid_q       <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awsize_q     <= '0;
      awburst_q    <= '0;
      awvalid_q    <= 1'b0;
      wid_q        <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wlast_q      <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      ifu_rlast_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
      lsu_bvalid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_lsu_q  <= owner_lsu_d;
      beat_q       <= beat_d;
      araddr_q     <= araddr_d;
      arid_q       <= arid_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awid_q       <= awid_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      awsize_q     <= awsize_d;
      awburst_q    <= awburst_d;
      awvalid_q    <= awvalid_d;
      wid_q        <= wid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wlast_q      <= wlast_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      ifu_rdata_q  <= ifu_rdata_d;
      ifu_rlast_q  <= ifu_rlast_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_rdata_q  <= lsu_rdata_d;
      lsu_bvalid_q <= lsu_bvalid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign araddr     = araddr_q;
  assign arid       = arid_q;
  assign arlen      = arlen_q;
  assign arsize     = arsize_q;
  assign arburst    = arburst_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awid       = awid_q;
  assign awaddr     = awaddr_q;
  assign awlen      = awlen_q;
  assign awsize     = awsize_q;
  assign awburst    = awburst_q;
  assign awvalid    = awvalid_q;
  assign wid        = wid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wlast      = wlast_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;
  assign ifu_rvalid = ifu_rvalid_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign ifu_rlast  = ifu_rlast_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign lsu_bvalid = lsu_bvalid_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench for axi_master_bridge: table-driven read and write
// transactions plus hand-written arbitration and reset-in-flight sequences.
module tb_axi_master_bridge;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_ready, ifu_rvalid, ifu_rlast;
  logic [63:0] ifu_rdata;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [2:0]  lsu_size = '0;
  logic [63:0] lsu_wdata = '0;
  logic [7:0]  lsu_wstrb = '0;
  logic        lsu_ready, lsu_rvalid, lsu_bvalid, resp_err;
  logic [63:0] lsu_rdata;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, wid;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [63:0] rdata = '0, wdata;
  logic [1:0]  rresp = '0, bresp = '0;

  always #5 aclk = ~aclk;

  axi_master_bridge dut (
    .aclk(aclk), .areset(areset),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_ready(lsu_ready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_bvalid(lsu_bvalid),
    .resp_err(resp_err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Move to the drive point of the next cycle
  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic        is_lsu;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [1:0]  resp;
    logic [31:0] exp_araddr;
    logic [3:0]  exp_arid;
    logic [7:0]  exp_arlen;
    logic [2:0]  exp_arsize;
    logic        exp_err;
  } rd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strb;
    int          da;
    int          dw;
    logic [1:0]  resp;
    logic        exp_err;
  } wr_vec_t;

  rd_vec_t rd_tbl[5];
  wr_vec_t wr_tbl[3];

  task automatic check_beat(input rd_vec_t v, input int k);
    logic [63:0] exp_data;
    exp_data = v.data + 64'(k);
    if (v.is_lsu) begin
      chk("lsu_rvalid", 64'(lsu_rvalid), 64'd1);
      chk("lsu_rdata", lsu_rdata, exp_data);
      chk("ifu_rvalid_idle", 64'(ifu_rvalid), 64'd0);
    end else begin
      chk("ifu_rvalid", 64'(ifu_rvalid), 64'd1);
      chk("ifu_rdata", ifu_rdata, exp_data);
      chk("ifu_rlast", 64'(ifu_rlast), 64'(k == int'(v.exp_arlen)));
    end
    chk("resp_err_r", 64'(resp_err), 64'(v.exp_err));
  endtask

  // Full read transaction; starts and ends at a drive point
  task automatic do_read(input rd_vec_t v);
    if (v.is_lsu) begin
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = v.addr; lsu_size = v.size;
    end else begin
      ifu_req = 1'b1; ifu_addr = v.addr;
    end
    #1;
    chk("rd_lsu_ready", 64'(lsu_ready), 64'(v.is_lsu));
    chk("rd_ifu_ready", 64'(ifu_ready), 64'(!v.is_lsu));
    next_cycle();
    ifu_req = 1'b0; lsu_req = 1'b0;
    #1;
    chk("ifu_ready_pulse", 64'(ifu_ready), 64'd0);
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("araddr", 64'(araddr), 64'(v.exp_araddr));
    chk("arid", 64'(arid), 64'(v.exp_arid));
    chk("arlen", 64'(arlen), 64'(v.exp_arlen));
    chk("arsize", 64'(arsize), 64'(v.exp_arsize));
    chk("arburst", 64'(arburst), 64'd1);
    arready = 1'b1;
    next_cycle();
    arready = 1'b0;
    for (int k = 0; k <= int'(v.exp_arlen); k++) begin
      rvalid = 1'b1; rdata = v.data + 64'(k); rresp = v.resp;
      rlast = (k == int'(v.exp_arlen));
      #1;
      chk("rready", 64'(rready), 64'd1);
      chk("arvalid_low", 64'(arvalid), 64'd0);
      if (k > 0) check_beat(v, k - 1);
      next_cycle();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
    check_beat(v, int'(v.exp_arlen));
    chk("rready_done", 64'(rready), 64'd0);
    next_cycle();
    chk("rvalid_pulse", 64'({ifu_rvalid, lsu_rvalid}), 64'd0);
    chk("resp_err_pulse", 64'(resp_err), 64'd0);
    next_cycle();
  endtask

  // Full LSU write; awready in cycle da, wready in cycle dw of the AW/W phase
  task automatic do_write(input wr_vec_t v);
    int last;
    last = (v.da > v.dw) ? v.da : v.dw;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = v.addr; lsu_size = v.size;
    lsu_wdata = v.data; lsu_wstrb = v.strb;
    #1;
    chk("wr_lsu_ready", 64'(lsu_ready), 64'd1);
    next_cycle();
    lsu_req = 1'b0; lsu_we = 1'b0;
    chk("awaddr", 64'(awaddr), 64'(v.addr));
    chk("awid", 64'(awid), 64'd1);
    chk("wid", 64'(wid), 64'd1);
    chk("awlen", 64'(awlen), 64'd0);
    chk("awsize", 64'(awsize), 64'(v.size));
    chk("awburst", 64'(awburst), 64'd1);
    chk("wdata", wdata, v.data);
    chk("wstrb", 64'(wstrb), 64'(v.strb));
    chk("wlast", 64'(wlast), 64'd1);
    chk("arvalid_wr", 64'(arvalid), 64'd0);
    for (int k = 0; k <= last; k++) begin
      chk("awvalid", 64'(awvalid), 64'(k <= v.da));
      chk("wvalid", 64'(wvalid), 64'(k <= v.dw));
      chk("bready_wait", 64'(bready), 64'd0);
      awready = (k == v.da);
      wready  = (k == v.dw);
      next_cycle();
    end
    awready = 1'b0; wready = 1'b0;
    chk("awvalid_done", 64'(awvalid), 64'd0);
    chk("wvalid_done", 64'(wvalid), 64'd0);
    chk("bready", 64'(bready), 64'd1);
    bvalid = 1'b1; bresp = v.resp;
    next_cycle();
    bvalid = 1'b0; bresp = 2'b00;
    chk("lsu_bvalid", 64'(lsu_bvalid), 64'd1);
    chk("resp_err_b", 64'(resp_err), 64'(v.exp_err));
    chk("bready_done", 64'(bready), 64'd0);
    next_cycle();
    chk("lsu_bvalid_pulse", 64'(lsu_bvalid), 64'd0);
    next_cycle();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valids"}, 64'({arvalid, rready, awvalid, wvalid, bready,
                               ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid,
                               lsu_bvalid, resp_err, ifu_rlast, wlast}), 64'd0);
    chk({nm, "_araddr"}, 64'(araddr), 64'd0);
    chk({nm, "_awaddr"}, 64'(awaddr), 64'd0);
    chk({nm, "_ifu_rdata"}, ifu_rdata, 64'd0);
    chk({nm, "_lsu_rdata"}, lsu_rdata, 64'd0);
    chk({nm, "_wdata"}, wdata, 64'd0);
  endtask

  initial begin
`ifdef IFU_BURST_EN
    rd_tbl[2] = '{1'b0, 32'h8000_0018, 3'd0, 64'hA5A5_0000_0000_0010, 2'b00,
                  32'h8000_0000, 4'd0, 8'd3, 3'd3, 1'b0};
`else
    rd_tbl[2] = '{1'b0, 32'h8000_0018, 3'd0, 64'hA5A5_0000_0000_0010, 2'b00,
                  32'h8000_0018, 4'd0, 8'd0, 3'd3, 1'b0};
`endif
    rd_tbl[0] = '{1'b0, 32'h8000_0000, 3'd0, 64'h1122_3344_5566_7788, 2'b00,
                  32'h8000_0000, 4'd0, 8'd0, 3'd3, 1'b0};
    rd_tbl[1] = '{1'b1, 32'h8000_2004, 3'd2, 64'h0000_00AB_CDEF_0123, 2'b00,
                  32'h8000_2004, 4'd1, 8'd0, 3'd2, 1'b0};
    rd_tbl[3] = '{1'b0, 32'h8000_0044, 3'd0, 64'hCAFE_F00D_1234_5678, 2'b10,
                  32'h8000_0044, 4'd0, 8'd0, 3'd3, 1'b1};
    rd_tbl[4] = '{1'b1, 32'h8000_0101, 3'd0, 64'h0000_0000_0000_005A, 2'b11,
                  32'h8000_0101, 4'd1, 8'd0, 3'd0, 1'b1};
`ifdef IFU_BURST_EN
    rd_tbl[3].exp_araddr = 32'h8000_0040;
    rd_tbl[3].exp_arlen  = 8'd3;
    rd_tbl[0].exp_arlen  = 8'd3;
`endif
    wr_tbl[0] = '{32'h8000_1004, 3'd2, 64'h0000_0000_DEAD_BEEF, 8'hF0, 0, 2, 2'b00, 1'b0};
    wr_tbl[1] = '{32'h8000_3000, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 2'b00, 1'b0};
    wr_tbl[2] = '{32'h8000_3008, 3'd1, 64'h0000_0000_0000_5555, 8'h03, 3, 1, 2'b10, 1'b1};

    // Reset state
    #1 areset = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    next_cycle();

    foreach (rd_tbl[i]) do_read(rd_tbl[i]);
    foreach (wr_tbl[i]) do_write(wr_tbl[i]);

    // LSU and IFU request together: LSU first, IFU after LSU completes
    ifu_req = 1'b1; ifu_addr = 32'h8000_0200;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_0300; lsu_size = 3'd3;
    #1;
    chk("prio_lsu_ready", 64'(lsu_ready), 64'd1);
    chk("prio_ifu_ready", 64'(ifu_ready), 64'd0);
    next_cycle();
    lsu_req = 1'b0;
    #1;
    chk("prio_arid_lsu", 64'(arid), 64'd1);
    chk("prio_araddr_lsu", 64'(araddr), 64'h8000_0300);
    chk("prio_ifu_wait", 64'(ifu_ready), 64'd0);
    arready = 1'b1;
    next_cycle();
    arready = 1'b0; rvalid = 1'b1; rdata = 64'h0BAD_F00D_0000_0001; rlast = 1'b1;
    next_cycle();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("prio_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
    chk("prio_lsu_rdata", lsu_rdata, 64'h0BAD_F00D_0000_0001);
    chk("prio_ifu_ready_after", 64'(ifu_ready), 64'd1);
    next_cycle();
    ifu_req = 1'b0;
    #1;
    chk("prio_arid_ifu", 64'(arid), 64'd0);
    chk("prio_arvalid_ifu", 64'(arvalid), 64'd1);
    arready = 1'b1;
    next_cycle();
    arready = 1'b0;
`ifdef IFU_BURST_EN
    chk("prio_araddr_ifu", 64'(araddr), 64'h8000_0200);
    rvalid = 1'b1; rdata = 64'h77;
    repeat (4) next_cycle();
    rvalid = 1'b0;
    #1;
    chk("prio_ifu_rlast", 64'(ifu_rlast), 64'd1);
`else
    chk("prio_araddr_ifu", 64'(araddr), 64'h8000_0200);
    rvalid = 1'b1; rdata = 64'h77; rlast = 1'b1;
    next_cycle();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("prio_ifu_rlast", 64'(ifu_rlast), 64'd1);
`endif
    chk("prio_ifu_rdata", ifu_rdata, 64'h77);
    next_cycle();
    next_cycle();

    // Reset while in R: everything clears at once, then a normal IFU read
    ifu_req = 1'b1; ifu_addr = 32'h8000_0400;
    next_cycle();
    ifu_req = 1'b0; arready = 1'b1;
    next_cycle();
    arready = 1'b0;
    chk("rst_in_r_rready", 64'(rready), 64'd1);
    ifu_req = 1'b1;
    areset = 1'b1;
    #1;
    chk_all_zero("rst_in_r");
    next_cycle();
    chk_all_zero("rst_held");
    areset = 1'b0; ifu_req = 1'b0;
    next_cycle();
    do_read(rd_tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound in case a sequence is broken
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
